sqrt_add_unit: RTL and testbench



---
 rtl/sqrt_add_unit_pkg.sv | 16 +
 rtl/sqrt_add_unit_if.sv | 23 ++
 rtl/sqrt_add_unit_step.sv | 29 ++
 rtl/sqrt_add_unit.sv | 81 ++++++++
 tb/tb_sqrt_add_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sqrt_add_unit_pkg.sv
// Shared widths and types for the non-restoring square-root datapath.
// QW is the root width, RW the signed working-remainder width (one sign bit plus headroom).
package sqrt_pkg;

    localparam int DW = 16;
    localparam int QW = DW / 2;
    localparam int RW = DW / 2 + 2;

    typedef logic signed [RW-1:0] rem_t;
    typedef logic        [QW-1:0] root_t;

    function automatic int root_width(input int dw);
        return dw / 2;
    endfunction

endpackage

// File: rtl/sqrt_add_unit_if.sv
// Controller-to-datapath bundle: step controls and radicand in, registered root/remainder/ready out.
interface sqrt_add_unit_if #(
    parameter int DW = 16
);
    logic          load;
    logic          start;
    logic          ctrl;
    logic [DW-1:0] D;
    logic [DW-1:0] excounter;
    logic [DW-1:0] Q;
    logic [DW-1:0] remainder;
    logic          ready;

    modport master (
        output load, start, ctrl, D, excounter,
        input  Q, remainder, ready
    );

    modport slave (
        input  load, start, ctrl, D, excounter,
        output Q, remainder, ready
    );
endinterface

// File: rtl/sqrt_add_unit_step.sv
// One non-restoring digit: combinational, zero latency, no handshake.
// The sign of the incoming remainder picks subtract or add; the sign of the result is the new root bit.
module sqrt_step #(
    parameter int QW = 8
) (
    input  logic signed [QW+1:0] r,
    input  logic        [QW-1:0] q,
    input  logic        [1:0]    pair,
    output logic signed [QW+1:0] r_next,
    output logic        [QW-1:0] q_next
);
    logic signed [QW+1:0] shifted;
    logic signed [QW+1:0] sub_term;
    logic signed [QW+1:0] add_term;

    assign shifted  = (r <<< 2) | {{QW{1'b0}}, pair};
    assign sub_term = {q, 2'b01};
    assign add_term = {q, 2'b11};

    always_comb begin
        r_next = shifted;
        if (!r[QW+1]) begin
            r_next = shifted - sub_term;
        end else begin
            r_next = shifted + add_term;
        end
        q_next = (q << 1) | {{(QW-1){1'b0}}, ~r_next[QW+1]};
    end
endmodule

// File: rtl/sqrt_add_unit.sv
// Integer square root datapath stepped one digit per clock by an external controller.
// Latency DW/2+2 clocks from load to ready; no backpressure, every asserted step executes on its edge.
module sqrt_add_unit
    import sqrt_pkg::*;
#(
    parameter int DW = sqrt_pkg::DW
) (
    input  logic            clk,
    input  logic            reset,
    sqrt_add_unit_if.slave  bus
);
    localparam int LQW = DW / 2;
    localparam int LRW = DW / 2 + 2;

    logic        [DW-1:0]  d_reg;
    logic        [LQW-1:0] q_reg;
    logic signed [LRW-1:0] r_reg;
    logic                  ready_reg;

    logic        [1:0]     pair;
    logic                  in_range;
    logic        [LQW-1:0] q_step;
    logic signed [LRW-1:0] r_step;
    logic signed [LRW-1:0] r_corr;

    // Mux the digit pair addressed by the controller's index.
    always_comb begin
        pair = 2'b00;
        for (int k = 0; k < LQW; k++) begin
            if (bus.excounter == DW'(k)) begin
                pair = d_reg[2*k +: 2];
            end
        end
    end

    assign in_range = (bus.excounter < DW'(LQW));

    sqrt_step #(
        .QW (LQW)
    ) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .pair   (pair),
        .r_next (r_step),
        .q_next (q_step)
    );

    // Final fix-up: a negative remainder is restored by adding back 2Q+1.
    always_comb begin
        r_corr = r_reg;
        if (r_reg[LRW-1]) begin
            r_corr = r_reg + {1'b0, q_reg, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            ready_reg <= 1'b0;
        end else if (bus.load) begin
            d_reg     <= bus.D;
            q_reg     <= '0;
            r_reg     <= '0;
            ready_reg <= 1'b0;
        end else if (bus.start) begin
            if (bus.ctrl) begin
                r_reg     <= r_corr;
                ready_reg <= 1'b1;
            end else if (in_range) begin
                r_reg <= r_step;
                q_reg <= q_step;
            end
        end
    end

    assign bus.Q         = {{(DW-LQW){1'b0}}, q_reg};
    assign bus.remainder = {{(DW-LQW-1){1'b0}}, r_reg[LQW:0]};
    assign bus.ready     = ready_reg;
endmodule

// File: tb/tb_sqrt_add_unit.sv
// Bench for sqrt_add_unit: table of radicands plus hand-written abort/pause/priority sequences.
module tb_sqrt_add_unit;
    localparam int DW = 16;

    logic clk;
    logic reset;

    sqrt_add_unit_if #(.DW(DW)) sif ();

    sqrt_add_unit #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        int            q;
        int            r;
    } vec_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    function automatic int isqrt(input int d);
        int q;
        q = 0;
        for (int b = 7; b >= 0; b--) begin
            if ((q | (1 << b)) * (q | (1 << b)) <= d) q = q | (1 << b);
        end
        return q;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic cyc(input logic ld, input logic st, input logic ct, input int ex);
        sif.load      = ld;
        sif.start     = st;
        sif.ctrl      = ct;
        sif.excounter = DW'(ex);
        @(posedge clk);
        #1;
        sif.load  = 1'b0;
        sif.start = 1'b0;
        sif.ctrl  = 1'b0;
    endtask

    task automatic do_load(input logic [DW-1:0] d);
        sif.D = d;
        cyc(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic iterate(input int from, input int to);
        for (int i = from; i >= to; i--) cyc(1'b0, 1'b1, 1'b0, i);
    endtask

    task automatic correct_and_check(input string name);
        exp_t e;
        int   w;
        cyc(1'b0, 1'b1, 1'b1, 0);
        w = 0;
        while (!sif.ready && w < 4) begin
            cyc(1'b0, 1'b0, 1'b0, 0);
            w++;
        end
        check({name, "_ready"}, int'(sif.ready), 1);
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({name, "_q"}, int'(sif.Q), e.q);
            check({name, "_rem"}, int'(sif.remainder), e.r);
        end
    endtask

    task automatic run_full(input logic [DW-1:0] d, input int q, input int r, input string name);
        sb.push_back('{q: q, r: r});
        do_load(d);
        check({name, "_ready_after_load"}, int'(sif.ready), 0);
        iterate(7, 0);
        correct_and_check(name);
    endtask

    initial begin
        vec_t vecs[6];
        logic [DW-1:0] rd;
        int   rq;

        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{d: 16'd127,   q: 11,  r: 6};
        vecs[1] = '{d: 16'd0,     q: 0,   r: 0};
        vecs[2] = '{d: 16'd144,   q: 12,  r: 0};
        vecs[3] = '{d: 16'd65535, q: 255, r: 510};
        vecs[4] = '{d: 16'd143,   q: 11,  r: 22};
        vecs[5] = '{d: 16'd1,     q: 1,   r: 0};

        sif.load = 1'b0; sif.start = 1'b0; sif.ctrl = 1'b0;
        sif.D = '0; sif.excounter = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_q", int'(sif.Q), 0);
        check("reset_rem", int'(sif.remainder), 0);
        check("reset_ready", int'(sif.ready), 0);

        for (int v = 0; v < 6; v++) begin
            run_full(vecs[v].d, vecs[v].q, vecs[v].r, $sformatf("vec%0d", v));
        end

        for (int n = 0; n < 8; n++) begin
            rd = DW'($urandom_range(0, 65535));
            rq = isqrt(int'(rd));
            run_full(rd, rq, int'(rd) - rq * rq, $sformatf("rand%0d", n));
        end

        // Reset mid-computation clears everything on that edge.
        do_load(16'd127);
        iterate(7, 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_q", int'(sif.Q), 0);
        check("midreset_rem", int'(sif.remainder), 0);
        check("midreset_ready", int'(sif.ready), 0);
        run_full(16'd127, 11, 6, "after_reset");

        // Out-of-range index is a no-op; idle cycles mid-sequence hold state.
        sb.push_back('{q: 255, r: 510});
        do_load(16'd65535);
        iterate(7, 4);
        check("partial_q", int'(sif.Q), 15);
        cyc(1'b0, 1'b1, 1'b0, 8);
        cyc(1'b0, 1'b1, 1'b0, 8);
        check("noop_q", int'(sif.Q), 15);
        check("noop_ready", int'(sif.ready), 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 3);
        check("pause_q", int'(sif.Q), 15);
        iterate(3, 0);
        correct_and_check("paused");

        // Extra correction steps leave the result alone.
        cyc(1'b0, 1'b1, 1'b1, 0);
        check("recorrect_q", int'(sif.Q), 255);
        check("recorrect_rem", int'(sif.remainder), 510);
        check("recorrect_ready", int'(sif.ready), 1);

        // Load after ready drops ready and restarts.
        run_full(16'd255, 15, 30, "reload");

        // Load wins over start in the same cycle and aborts the previous run.
        do_load(16'd65535);
        iterate(7, 5);
        sb.push_back('{q: 11, r: 22});
        sif.D = 16'd143;
        cyc(1'b1, 1'b1, 1'b0, 4);
        check("load_wins_q", int'(sif.Q), 0);
        check("load_wins_ready", int'(sif.ready), 0);
        iterate(7, 0);
        correct_and_check("abort_restart");

        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
